gol_pixel_renderer: RTL

//  Pixel stage directly downstream of the vga timing generator. Maps each active
//  (x,y) to a Game-of-Life cell and reads that cell's alive bit from the cell

---
 rtl/gol_pixel_renderer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gol_pixel_renderer.sv
// gol_pixel_renderer
//   Pixel stage that sits directly after the VGA timing generator. Each active
//   (x,y) is mapped to a Game-of-Life cell. The cell's alive bit is read from
//   the frame buffer through a synchronous read port with a one-cycle latency.
//   The stage produces RGB444 with optional grid lines, a cursor outline and a
//   border colour outside the grid. h/v sync are delayed so that they stay
//   aligned with the RGB output. The latency is 3 clocks, one pixel per clock.
// Ports
//   clk, rst                 pixel clock, synchronous active-high reset
//   i_draw_active            pixel is inside the visible area
//   i_active_x / i_active_y  pixel column / row
//   i_h_sync / i_v_sync      raw syncs from the timing generator
//   i_cursor_x / i_cursor_y  cursor cell column / row
//   o_cell_rd_en/o_cell_addr frame-buffer read request (addr = cy*GRID_W + cx)
//   i_cell_data              alive bit, valid one cycle after o_cell_rd_en
//   o_rgb                    {R,G,B} 4 bits each
//   o_h_sync / o_v_sync      syncs delayed to match o_rgb
module gol_pixel_renderer #(
   parameter int          H_ACTIVE     = 640,
   parameter int          V_ACTIVE     = 480,
   parameter int          CELL_LOG2    = 3,
   parameter int          GRID_W       = 80,
   parameter int          GRID_H       = 60,
   parameter bit          GRID_LINES   = 1'b1,
   parameter logic        SYNC_IDLE    = 1'b1,
   parameter logic [11:0] ALIVE_COLOR  = 12'hFFF,
   parameter logic [11:0] DEAD_COLOR   = 12'h000,
   parameter logic [11:0] GRID_COLOR   = 12'h333,
   parameter logic [11:0] CURSOR_COLOR = 12'hF00,
   parameter logic [11:0] BORDER_COLOR = 12'h00F
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               i_draw_active,
   input  logic [$clog2(H_ACTIVE)-1:0]        i_active_x,
   input  logic [$clog2(V_ACTIVE)-1:0]        i_active_y,
   input  logic                               i_h_sync,
   input  logic                               i_v_sync,
   input  logic [$clog2(GRID_W)-1:0]          i_cursor_x,
   input  logic [$clog2(GRID_H)-1:0]          i_cursor_y,
   output logic                               o_cell_rd_en,
   output logic [$clog2(GRID_W*GRID_H)-1:0]   o_cell_addr,
   input  logic                               i_cell_data,
   output logic [11:0]                        o_rgb,
   output logic                               o_h_sync,
   output logic                               o_v_sync
);

   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   localparam int AW = $clog2(GRID_W*GRID_H);
   localparam logic [CELL_LOG2-1:0] OFS_MAX = {CELL_LOG2{1'b1}};

   // Stage-1 decode of the incoming pixel
   logic [XW-1:0]        cx_s;
   logic [YW-1:0]        cy_s;
   logic [CELL_LOG2-1:0] ox_s;
   logic [CELL_LOG2-1:0] oy_s;
   logic                 in_grid_s;
   logic                 grid_edge_s;
   logic                 cursor_hit_s;
   logic [AW-1:0]        addr_s;

   // Pipeline flags
   logic active_s1_r, in_grid_s1_r, cursor_s1_r, grid_s1_r;
   logic active_s2_r, in_grid_s2_r, cursor_s2_r, grid_s2_r;
   logic h_sync_s1_r, v_sync_s1_r, h_sync_s2_r, v_sync_s2_r;
   logic [11:0] rgb_next_s;

   assign cx_s = i_active_x >> CELL_LOG2;
   assign cy_s = i_active_y >> CELL_LOG2;
   assign ox_s = i_active_x[CELL_LOG2-1:0];
   assign oy_s = i_active_y[CELL_LOG2-1:0];

   // Cell classification: grid membership, grid edge, cursor outline, address
   always_comb begin
      in_grid_s    = i_draw_active && (cx_s < XW'(GRID_W)) && (cy_s < YW'(GRID_H));
      grid_edge_s  = (ox_s == {CELL_LOG2{1'b0}}) || (oy_s == {CELL_LOG2{1'b0}});
      // The cursor outline uses all four edges of the cell, not just offset 0
      cursor_hit_s = (cx_s == XW'(i_cursor_x)) && (cy_s == YW'(i_cursor_y)) &&
                     (grid_edge_s || (ox_s == OFS_MAX) || (oy_s == OFS_MAX));
      addr_s       = AW'(cy_s) * AW'(GRID_W) + AW'(cx_s);
   end

   // S1: register the read request, the pixel flags and the syncs
   always_ff @(posedge clk) begin
      if (rst) begin
         o_cell_rd_en <= 1'b0;
         o_cell_addr  <= {AW{1'b0}};
         active_s1_r  <= 1'b0;
         in_grid_s1_r <= 1'b0;
         cursor_s1_r  <= 1'b0;
         grid_s1_r    <= 1'b0;
         h_sync_s1_r  <= SYNC_IDLE;
         v_sync_s1_r  <= SYNC_IDLE;
      end else begin
         o_cell_rd_en <= in_grid_s;
         // Off-grid pixels leave the address unchanged
         if (in_grid_s) begin
            o_cell_addr <= addr_s;
         end else begin
            o_cell_addr <= o_cell_addr;
         end
         active_s1_r  <= i_draw_active;
         in_grid_s1_r <= in_grid_s;
         cursor_s1_r  <= cursor_hit_s;
         grid_s1_r    <= grid_edge_s;
         h_sync_s1_r  <= i_h_sync;
         v_sync_s1_r  <= i_v_sync;
      end
   end

   // S2: advance flags and syncs while the frame buffer performs the read
   always_ff @(posedge clk) begin
      if (rst) begin
         active_s2_r  <= 1'b0;
         in_grid_s2_r <= 1'b0;
         cursor_s2_r  <= 1'b0;
         grid_s2_r    <= 1'b0;
         h_sync_s2_r  <= SYNC_IDLE;
         v_sync_s2_r  <= SYNC_IDLE;
      end else begin
         active_s2_r  <= active_s1_r;
         in_grid_s2_r <= in_grid_s1_r;
         cursor_s2_r  <= cursor_s1_r;
         grid_s2_r    <= grid_s1_r;
         h_sync_s2_r  <= h_sync_s1_r;
         v_sync_s2_r  <= v_sync_s1_r;
      end
   end

   // Colour priority: blank, border, cursor, grid line, then cell state.
   // i_cell_data only reaches the output when in_grid (i.e. rd_en) was set.
   always_comb begin
      rgb_next_s = 12'h000;
      if (!active_s2_r) begin
         rgb_next_s = 12'h000;
      end else if (!in_grid_s2_r) begin
         rgb_next_s = BORDER_COLOR;
      end else if (cursor_s2_r) begin
         rgb_next_s = CURSOR_COLOR;
      end else if (GRID_LINES && grid_s2_r) begin
         rgb_next_s = GRID_COLOR;
      end else if (i_cell_data) begin
         rgb_next_s = ALIVE_COLOR;
      end else begin
         rgb_next_s = DEAD_COLOR;
      end
   end

   // S3: registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         o_rgb    <= 12'h000;
         o_h_sync <= SYNC_IDLE;
         o_v_sync <= SYNC_IDLE;
      end else begin
         o_rgb    <= rgb_next_s;
         o_h_sync <= h_sync_s2_r;
         o_v_sync <= v_sync_s2_r;
      end
   end

endmodule
